seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of time-multiplexed 7-seg digits (legal 2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 50000, meaning clk cycles each digit is driven (legal >= 4).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, meaning anti-ghost blank cycles between digits (legal 0..DWELL_CYCLES-1).
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  scan enable; 0 forces all digits off.
REQ-007 SHALL have port bcd_in  input  4*NUM_DIGITS  digit values, digit 0 in bits [3:0].
REQ-008 SHALL have port load  input  1  request to update the displayed value.
REQ-009 SHALL have port load_ack  output  1  one-cycle pulse when bcd_in is captured.
REQ-010 SHALL have port bcd_out  output  4  code for the shared bcd_to_7seg decoder.
REQ-011 SHALL have port digit_sel  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last digit's dwell.

Function
REQ-013 SHALL implement states IDLE, DRIVE and GAP.
REQ-014 IDLE: digit_sel all 1, bcd_out 4'hF; go to DRIVE with digit index 0 on the first cycle en=1.
REQ-015 DRIVE: assert digit_sel[idx]=0 and bcd_out=shadow[idx] for exactly DWELL_CYCLES cycles, then go to GAP (or, if GAP_CYCLES=0, go directly to the next DRIVE).
REQ-016 GAP: digit_sel all 1, bcd_out 4'hF for GAP_CYCLES cycles, then go to DRIVE with idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 frame_done SHALL pulse in the cycle that the dwell of idx=NUM_DIGITS-1 ends.
REQ-018 Values SHALL be displayed only from the internal shadow register, never directly from bcd_in.
REQ-019 load SHALL be held until load_ack; capture SHALL occur only at a frame boundary (frame_done cycle) or in IDLE, so that no frame tears.
REQ-020 In IDLE, a load request SHALL be captured in the next cycle; load_ack SHALL be registered and coincide with the shadow update.
REQ-021 Digit codes 10..15 SHALL pass through unchanged; the decoder blanks them.
REQ-022 If en falls mid-dwell, the block SHALL enter IDLE next cycle, the dwell counter and idx SHALL reset, and a pending load SHALL be serviced from IDLE.
REQ-023 If en=1 and load=1 in the same cycle while in IDLE, the block SHALL capture first and start DRIVE in the following cycle using the new value.
REQ-024 The dwell/gap counter SHALL be $clog2(DWELL_CYCLES) bits wide and SHALL never overflow.
REQ-025 At least one cycle SHALL separate any two digit_sel low bits; no two digits SHALL ever be low simultaneously.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, idx=0, counter=0, shadow all 4'hF, digit_sel all 1, bcd_out 4'hF, load_ack=0, frame_done=0.
REQ-027 Release of reset SHALL take effect on the next rising clk edge.

Configuration
REQ-028 With macro SEG_SCAN_LZB_EN defined, leading-zero blanking SHALL apply: any digit whose value and all higher digits' values are 0 SHALL output bcd_out 4'hF; digit 0 SHALL never be blanked.
REQ-029 Without SEG_SCAN_LZB_EN, all shadow digits SHALL be output unmodified, and no blanking logic SHALL be synthesized.

Structure
REQ-030 Shared package seg_pkg SHALL hold the state enum, the BCD_BLANK=4'hF constant, and the NUM_DIGITS legality check.
REQ-031 The dwell/gap counter SHALL be a sub-module named scan_timer, with inputs start and length and output a done pulse.
REQ-032 The bcd_to_7seg decoder SHALL remain external and be driven by bcd_out.

Verification (NUM_DIGITS=4, DWELL_CYCLES=8, GAP_CYCLES=2)
REQ-033 Scenario 1 -- reset, en=1, load 16'h1234 -> load_ack next cycle; digit_sel 1110/1101/1011/0111 with bcd_out 4,3,2,1 for 8 cycles each; 2-cycle 1111 gaps.
REQ-034 Scenario 2 -- load 16'h5678 mid-frame -> no load_ack until the frame_done cycle; the next frame shows 8,7,6,5.
REQ-035 Scenario 3 -- en dropped on dwell cycle 3 of digit 2 -> next cycle digit_sel=1111 in IDLE; on en=1 the scan restarts at digit 0.
REQ-036 Scenario 4 -- SEG_SCAN_LZB_EN defined, load 16'h0050 -> digits 3 and 2 output 4'hF, digit 1 outputs 5, digit 0 outputs 0; macro undefined -> 0,0,5,0 shown.
REQ-037 Scenario 5 -- rst asserted mid-GAP -> all outputs reach reset values without a clock edge; the shadow reads 4'hF.
REQ-038 Scenario 6 -- check every cycle for 10 frames -> popcount(~digit_sel) <= 1, and exactly one frame_done per 40 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seg_scan_ctrl time-multiplexed 7-segment scanner.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } scan_state_e;

    localparam logic [3:0] BCD_BLANK      = 4'hF;
    localparam int         NUM_DIGITS_MIN = 2;
    localparam int         NUM_DIGITS_MAX = 8;

    function automatic bit num_digits_legal(input int n);
        return (n >= NUM_DIGITS_MIN) && (n <= NUM_DIGITS_MAX);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counting dwell/gap timer: start loads the terminal count (cycles - 1),
// done pulses on the last counted cycle, clr abandons the count.
module scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] length,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (clr) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start) begin
            cnt_d  = length;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment digit scanner with a frame-synchronous shadow register.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int               IDX_W     = $clog2(NUM_DIGITS);
    localparam int               CNT_W     = $clog2(DWELL_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LEN = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (!num_digits_legal(NUM_DIGITS)) begin : g_bad_num_digits
        $error("seg_scan_ctrl: NUM_DIGITS must be in 2..8");
    end

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic                    load_ack_q;
    logic                    capture;
    logic                    tmr_start, tmr_clr, tmr_done;
    logic [CNT_W-1:0]        tmr_len;
    logic [3:0]              digit_raw, digit_val;

    scan_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (tmr_start),
        .clr    (tmr_clr),
        .length (tmr_len),
        .done   (tmr_done)
    );

    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_start  = 1'b0;
        tmr_clr    = 1'b0;
        tmr_len    = DWELL_LEN;
        capture    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Capture takes priority so the first frame after enable shows the new value.
                if (load && !load_ack_q) begin
                    capture = 1'b1;
                end else if (en) begin
                    state_d   = DRIVE;
                    idx_d     = '0;
                    tmr_start = 1'b1;
                end
            end
            DRIVE: begin
                if (tmr_done && (idx_q == LAST_IDX)) begin
                    frame_done = 1'b1;
                    capture    = load && !load_ack_q;
                end
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_done) begin
                    tmr_start = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        tmr_len = GAP_LEN;
                    end else begin
                        idx_d = idx_next;
                    end
                end
            end
            GAP: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_done) begin
                    state_d   = DRIVE;
                    idx_d     = idx_next;
                    tmr_start = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: the shadow is a register bank, not a RAM, so it is reset to blank codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shadow_q   <= {NUM_DIGITS{BCD_BLANK}};
            load_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_ack_q <= capture;
            if (capture) begin
                shadow_q <= bcd_in;
            end
        end
    end

    assign digit_raw = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (shadow_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end

    assign digit_val = lz_blank[idx_q] ? BCD_BLANK : digit_raw;
`else
    assign digit_val = digit_raw;
`endif

    always_comb begin
        digit_sel = '1;
        bcd_out   = BCD_BLANK;
        if (state_q == DRIVE) begin
            bcd_out = digit_val;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_sel[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    assign load_ack = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl (4 digits, dwell 8, gap 2).
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 8;
    localparam int GC    = 2;
    localparam int SLOT  = DW + GC;
    localparam int FRAME = ND * SLOT;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        load_ack, frame_done;
    logic [3:0]  bcd_out, digit_sel;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;

    // Observation word: {digit_sel, bcd_out, frame_done, load_ack}
    typedef logic [9:0] obs_t;
    obs_t exp_q[$];

    // Reference model: scan position within a frame, displayed shadow, ack flag.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_shadow;
    bit          m_ack;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .GAP_CYCLES   (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .load       (load),
        .load_ack   (load_ack),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic obs_t model_obs();
        obs_t        o;
        int          d;
        logic [3:0]  sel;
        logic [15:0] upper;
        sel = 4'hF;
        o   = {4'hF, 4'hF, 1'b0, m_ack};
        if (m_run && (m_pos % SLOT) < DW) begin
            d      = m_pos / SLOT;
            sel[d] = 1'b0;
            upper  = m_shadow >> (4 * d);
            o[9:6] = sel;
            o[5:2] = upper[3:0];
`ifdef SEG_SCAN_LZB_EN
            if (d > 0 && upper == 16'h0) o[5:2] = 4'hF;
`endif
        end
        o[1] = m_run && (m_pos == FRAME - GC - 1);
        return o;
    endfunction

    // Model: advance at each rising edge using the inputs the DUT sees.
    initial forever begin
        bit cap;
        @(posedge clk);
        if (rst) begin
            m_run    = 1'b0;
            m_pos    = 0;
            m_shadow = 16'hFFFF;
            m_ack    = 1'b0;
            exp_q.delete();
        end else begin
            cap = 1'b0;
            if (!m_run) begin
                if (load && !m_ack) cap = 1'b1;
                else if (en) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end else begin
                if (m_pos == FRAME - GC - 1 && load && !m_ack) cap = 1'b1;
                if (!en) m_run = 1'b0;
                else m_pos = (m_pos + 1) % FRAME;
            end
            if (cap) m_shadow = bcd_in;
            m_ack = cap;
            exp_q.push_back(model_obs());
        end
    end

    // Monitor: compare on the falling edge, away from the active edge.
    initial forever begin
        obs_t e;
        @(negedge clk);
        if (!rst) begin
            check("single_digit_low", 32'($countones(~digit_sel) <= 1), 1);
            if (frame_done) fd_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scan_obs", {22'b0, digit_sel, bcd_out, frame_done, load_ack}, {22'b0, e});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, output int lat);
        bcd_in = v;
        load   = 1'b1;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!load_ack && lat < 200);
        check("load_ack_seen", 32'(load_ack), 1);
        load = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] target, input string name);
        int k = 0;
        while (digit_sel !== target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(digit_sel), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          fd0;
        logic [15:0] v;

        cycles(3);
        check("rst_digit_sel", 32'(digit_sel), 'hF);
        check("rst_bcd_out", 32'(bcd_out), 'hF);
        check("rst_load_ack", 32'(load_ack), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Enable and load together from IDLE.
        en = 1'b1;
        do_load(16'h1234, lat);
        check("idle_ack_latency", lat, 1);
        cycles(2 * FRAME);

        // Mid-frame load waits for the frame boundary.
        wait_sel(4'b1101, "reach_digit1");
        do_load(16'h5678, lat);
        check("midframe_ack_deferred", 32'(lat > 1), 1);
        cycles(FRAME);

        // Leading zeros (blanked only when SEG_SCAN_LZB_EN is defined).
        do_load(16'h0050, lat);
        cycles(FRAME + 5);

        // Random values, including codes 10..15, with occasional enable drops.
        for (int i = 0; i < 8; i++) begin
            cycles($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                cycles($urandom_range(1, 4));
                en = 1'b1;
            end
            v = 16'($urandom);
            if (i % 3 == 0) v = v & 16'h00F0;
            do_load(v, lat);
        end
        cycles(FRAME);

        // Load serviced from IDLE while disabled.
        en = 1'b0;
        @(negedge clk);
        do_load(16'h0A09, lat);
        check("idle_ack_en_low", lat, 1);
        en = 1'b1;
        cycles(FRAME);

        // Enable dropped on dwell cycle 3 of digit 2.
        wait_sel(4'b1101, "reach_digit1_b");
        wait_sel(4'b1011, "reach_digit2");
        cycles(2);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_sel_off", 32'(digit_sel), 'hF);
        check("en_drop_bcd_blank", 32'(bcd_out), 'hF);
        cycles(3);
        en = 1'b1;
        @(negedge clk);
        check("restart_digit0", 32'(digit_sel), 'hE);

        // Ten frames of continuous scanning: one frame_done per frame.
        cycles(FRAME);
        #1 fd0 = fd_count;
        cycles(10 * FRAME);
        #1 check("frame_done_count", fd_count - fd0, 10);

        // Asynchronous reset in the middle of a gap.
        wait_sel(4'b0111, "reach_digit3");
        wait_sel(4'hF, "reach_gap");
        #2 rst = 1'b1;
        #1;
        check("async_rst_digit_sel", 32'(digit_sel), 'hF);
        check("async_rst_bcd_out", 32'(bcd_out), 'hF);
        check("async_rst_load_ack", 32'(load_ack), 0);
        check("async_rst_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        cycles(FRAME + 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
